mm_store_buffer: RTL and testbench

- Post-MM store buffer; the receiving end of the MM stage store-buffer enable and store data.
- Queues retired stores in order and drains them one at a time to the data cache through a req / addr_ok / data_ok handshake.
- Reports load-versus-pending-store address hazards back to the MM stage so a younger load stalls.
- Entries are architecturally committed on entry; exception flush never drops them.

---
 rtl/mm_store_buffer_pkg.sv | 21 ++
 rtl/mm_store_buffer_match.sv | 60 ++++++
 rtl/mm_store_buffer.sv | 193 +++++++++++++++++++
 tb/tb_mm_store_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_store_buffer_pkg.sv
// Shared types and entry layout for the post-MM store buffer.
// Entry = {addr, wdata, wstrb, uncache}, LSB first: uncache, wstrb, wdata, addr.
`ifndef MM_TO_SB_BUS_WD
`define MM_TO_SB_BUS_WD 70
`endif

package mm_store_buffer_pkg;

   typedef enum logic [1:0] {
      SB_IDLE = 2'd0,
      SB_REQ  = 2'd1,
      SB_WAIT = 2'd2
   } sb_state_e;

   localparam int SB_UNC_BIT  = 0;
   localparam int SB_STRB_LSB = 1;
   localparam int SB_DATA_LSB = 5;
   localparam int SB_ADDR_LSB = 37;
   localparam int SB_FIXED_W  = 37;

endpackage

// File: rtl/mm_store_buffer_match.sv
// Per-entry word-address compare and youngest-match select.
// Forwarding select exists only with MM_STORE_BUFFER_FWD_EN.
module mm_store_buffer_match #(
   parameter int SB_DEPTH = 4,
   parameter int ADDR_W   = 32
) (
   input  logic [SB_DEPTH-1:0]            valid,
   input  logic [SB_DEPTH*(ADDR_W-2)-1:0] tags,
   input  logic [ADDR_W-3:0]              ld_tag,
`ifdef MM_STORE_BUFFER_FWD_EN
   input  logic [$clog2(SB_DEPTH)-1:0]    head,
   input  logic [SB_DEPTH*32-1:0]         data,
   input  logic [SB_DEPTH*4-1:0]          strb,
   input  logic [SB_DEPTH-1:0]            unc,
   output logic                           fwd_ok,
   output logic [31:0]                    fwd_data,
`endif
   output logic                           any_match
);

   logic [SB_DEPTH-1:0] hit;

   // word-granular address match against every live entry
   always_comb begin
      hit = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         hit[i] = valid[i] &&
                  (tags[i*(ADDR_W-2) +: ADDR_W-2] == ld_tag);
      end
   end

   assign any_match = |hit;

`ifdef MM_STORE_BUFFER_FWD_EN
   localparam int PW = $clog2(SB_DEPTH);

   logic [PW-1:0] idx;
   logic [PW-1:0] sel;
   logic          found;

   // walk oldest to youngest; the last hit seen is the youngest store
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         idx = head + PW'(k);
         if (hit[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   assign fwd_ok   = found && !unc[sel] &&
                     (strb[sel*4 +: 4] == 4'hf);
   assign fwd_data = data[sel*32 +: 32];
`endif

endmodule

// File: rtl/mm_store_buffer.sv
// Post-MM store buffer: in-order queue of retired stores drained to dcache.
// Optional load forwarding enabled by defining MM_STORE_BUFFER_FWD_EN.
module mm_store_buffer
   import mm_store_buffer_pkg::*;
#(
   parameter int SB_DEPTH = 4,
   parameter int PTR_W    = 2,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              store_buffer_ce_i,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [31:0]       st_wdata_i,
   input  logic [3:0]        st_wstrb_i,
   input  logic              st_uncache_i,
   output logic              sb_full_o,
   output logic              sb_empty_o,
   output logic              dcache_req_o,
   output logic [ADDR_W-1:0] dcache_addr_o,
   output logic [31:0]       dcache_wdata_o,
   output logic [3:0]        dcache_wstrb_o,
   output logic              dcache_uncache_o,
   input  logic              dcache_addr_ok_i,
   input  logic              dcache_data_ok_i,
   input  logic              ld_valid_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   output logic              ld_hazard_o,
   output logic              ld_fwd_hit_o,
   output logic [31:0]       ld_fwd_data_o
);

   localparam int E_W = SB_FIXED_W + ADDR_W;

   logic [E_W-1:0]      mem [SB_DEPTH];
   logic [SB_DEPTH-1:0] valid;
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [PTR_W:0]      count;
   sb_state_e           state;
   sb_state_e           state_nxt;
   logic                push;
   logic                pop;
   logic                more;
   logic [E_W-1:0]      head_e;
   logic [E_W-1:0]      wr_e;
   logic                any_match;

   logic [SB_DEPTH*(ADDR_W-2)-1:0] tags;

   assign sb_full_o  = (count == (PTR_W+1)'(SB_DEPTH));
   assign sb_empty_o = (count == '0) && (state == SB_IDLE);
   assign push       = store_buffer_ce_i && !sb_full_o;
   assign more       = (count > (PTR_W+1)'(1)) ||
                       ((count == (PTR_W+1)'(1)) && push);

   assign wr_e = {st_addr_i, st_wdata_i, st_wstrb_i, st_uncache_i};

   assign head_e           = mem[head];
   assign dcache_addr_o    = head_e[SB_ADDR_LSB +: ADDR_W];
   assign dcache_wdata_o   = head_e[SB_DATA_LSB +: 32];
   assign dcache_wstrb_o   = head_e[SB_STRB_LSB +: 4];
   assign dcache_uncache_o = head_e[SB_UNC_BIT];

   // drain FSM: one outstanding write, head popped only on data_ok
   always_comb begin
      state_nxt    = state;
      dcache_req_o = 1'b0;
      pop          = 1'b0;
      case (state)
         SB_IDLE: begin
            if (count != '0) state_nxt = SB_REQ;
         end
         SB_REQ: begin
            dcache_req_o = 1'b1;
            if (dcache_addr_ok_i) begin
               if (dcache_data_ok_i) begin
                  pop       = 1'b1;
                  state_nxt = more ? SB_REQ : SB_IDLE;
               end else begin
                  state_nxt = SB_WAIT;
               end
            end
         end
         SB_WAIT: begin
            if (dcache_data_ok_i) begin
               pop       = 1'b1;
               state_nxt = more ? SB_REQ : SB_IDLE;
            end
         end
         default: state_nxt = SB_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SB_IDLE;
      else        state <= state_nxt;
   end

   // circular queue: enqueue at tail, retire at head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         for (int i = 0; i < SB_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[tail]   <= wr_e;
            valid[tail] <= 1'b1;
            tail        <= tail + PTR_W'(1);
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // word tags of all entries for the load hazard compare
   always_comb begin
      tags = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         tags[i*(ADDR_W-2) +: ADDR_W-2] =
            mem[i][SB_ADDR_LSB+2 +: ADDR_W-2];
      end
   end

   logic unused_ld_lo;
   assign unused_ld_lo = ^ld_addr_i[1:0];

`ifdef MM_STORE_BUFFER_FWD_EN
   logic [SB_DEPTH*32-1:0] data_f;
   logic [SB_DEPTH*4-1:0]  strb_f;
   logic [SB_DEPTH-1:0]    unc_f;
   logic                   fwd_ok;
   logic [31:0]            fwd_data;

   // flatten data, strobes and uncached flags for the forward select
   always_comb begin
      data_f = '0;
      strb_f = '0;
      unc_f  = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         data_f[i*32 +: 32] = mem[i][SB_DATA_LSB +: 32];
         strb_f[i*4 +: 4]   = mem[i][SB_STRB_LSB +: 4];
         unc_f[i]           = mem[i][SB_UNC_BIT];
      end
   end

   mm_store_buffer_match #(
      .SB_DEPTH (SB_DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_match (
      .valid     (valid),
      .tags      (tags),
      .ld_tag    (ld_addr_i[ADDR_W-1:2]),
      .head      (head),
      .data      (data_f),
      .strb      (strb_f),
      .unc       (unc_f),
      .fwd_ok    (fwd_ok),
      .fwd_data  (fwd_data),
      .any_match (any_match)
   );

   assign ld_fwd_hit_o  = ld_valid_i && fwd_ok;
   assign ld_fwd_data_o = ld_fwd_hit_o ? fwd_data : 32'h0;
   assign ld_hazard_o   = ld_valid_i && any_match && !fwd_ok;
`else
   mm_store_buffer_match #(
      .SB_DEPTH (SB_DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_match (
      .valid     (valid),
      .tags      (tags),
      .ld_tag    (ld_addr_i[ADDR_W-1:2]),
      .any_match (any_match)
   );

   assign ld_fwd_hit_o  = 1'b0;
   assign ld_fwd_data_o = 32'h0;
   assign ld_hazard_o   = ld_valid_i && any_match;
`endif

endmodule

// File: tb/tb_mm_store_buffer.sv
// Directed bench for mm_store_buffer.
// Forwarding expectations follow MM_STORE_BUFFER_FWD_EN.
module tb_mm_store_buffer;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic        st_unc;
   logic        full;
   logic        empty;
   logic        req;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_unc;
   logic        addr_ok;
   logic        data_ok;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        hazard;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   int checks;
   int failures;

   logic [31:0] ea_q[$];
   logic [31:0] ed_q[$];

   mm_store_buffer #(
      .SB_DEPTH (4),
      .PTR_W    (2),
      .ADDR_W   (32)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .store_buffer_ce_i(ce),
      .st_addr_i        (st_addr),
      .st_wdata_i       (st_wdata),
      .st_wstrb_i       (st_wstrb),
      .st_uncache_i     (st_unc),
      .sb_full_o        (full),
      .sb_empty_o       (empty),
      .dcache_req_o     (req),
      .dcache_addr_o    (d_addr),
      .dcache_wdata_o   (d_wdata),
      .dcache_wstrb_o   (d_wstrb),
      .dcache_uncache_o (d_unc),
      .dcache_addr_ok_i (addr_ok),
      .dcache_data_ok_i (data_ok),
      .ld_valid_i       (ld_valid),
      .ld_addr_i        (ld_addr),
      .ld_hazard_o      (hazard),
      .ld_fwd_hit_o     (fwd_hit),
      .ld_fwd_data_o    (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic enq(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input logic        u);
      ce       = 1'b1;
      st_addr  = a;
      st_wdata = d;
      st_wstrb = s;
      st_unc   = u;
      step();
      ce = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n       = 0;
      addr_ok = 1'b1;
      data_ok = 1'b1;
      while (n < 40 && !(empty && ea_q.size() == 0)) begin
         settle();
         if (req) begin
            if (ea_q.size() == 0) begin
               chk({tag, "_extra"}, d_addr, 64'hdead);
            end else begin
               chk({tag, "_addr"}, d_addr, ea_q.pop_front());
               chk({tag, "_data"}, d_wdata, ed_q.pop_front());
            end
         end
         step();
         n++;
      end
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_left"}, ea_q.size(), 0);
      ea_q.delete();
      ed_q.delete();
      addr_ok = 1'b0;
      data_ok = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      ce       = 1'b0;
      st_addr  = '0;
      st_wdata = '0;
      st_wstrb = '0;
      st_unc   = 1'b0;
      addr_ok  = 1'b0;
      data_ok  = 1'b0;
      ld_valid = 1'b0;
      ld_addr  = '0;

      // reset values
      #3;
      chk("rst_req", req, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_hazard", hazard, 0);
      chk("rst_fwd_hit", fwd_hit, 0);
      chk("rst_fwd_data", fwd_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // single store latency: req in cycles 2-3
      enq_lat: begin
         ce = 1'b1; st_addr = 32'h1000;
         st_wdata = 32'h11223344; st_wstrb = 4'hf;
         st_unc = 1'b0;
         settle(); chk("lat_c0_empty", empty, 1);
         step(); ce = 1'b0;
         settle(); chk("lat_c1_req", req, 0);
         chk("lat_c1_empty", empty, 0);
         step();
         settle(); chk("lat_c2_req", req, 1);
         chk("lat_c2_addr", d_addr, 32'h1000);
         chk("lat_c2_data", d_wdata, 32'h11223344);
         chk("lat_c2_strb", d_wstrb, 4'hf);
         step(); addr_ok = 1'b1;
         settle(); chk("lat_c3_req", req, 1);
         step(); addr_ok = 1'b0;
         settle(); chk("lat_c4_req", req, 0);
         step(); data_ok = 1'b1;
         settle(); chk("lat_c5_empty", empty, 0);
         step(); data_ok = 1'b0;
         settle(); chk("lat_c6_empty", empty, 1);
         chk("lat_c6_req", req, 0);
         step();
      end

      // load hazard against a pending partial store
      enq(32'h1004, 32'h55667788, 4'h3, 1'b0);
      ld_valid = 1'b1; ld_addr = 32'h1004;
      settle(); chk("hz_same", hazard, 1);
      ld_addr = 32'h1008; #1 chk("hz_other", hazard, 0);
      ld_addr = 32'h1006; #1 chk("hz_word", hazard, 1);
      ld_valid = 1'b0;    #1 chk("hz_novalid", hazard, 0);
      ld_valid = 1'b1; ld_addr = 32'h1004;
      step(); addr_ok = 1'b1;
      settle(); chk("hz_req", hazard, 1);
      step(); addr_ok = 1'b0;
      settle(); chk("hz_wait", hazard, 1);
      step(); data_ok = 1'b1;
      settle(); chk("hz_dataok", hazard, 1);
      step(); data_ok = 1'b0;
      settle(); chk("hz_gone", hazard, 0);
      chk("hz_empty", empty, 1);
      ld_valid = 1'b0;
      step();

      // push and pop in one cycle at count 2; tail wraps 3->0
      enq(32'h3000, 32'hA0, 4'hf, 1'b0);
      enq(32'h3004, 32'hB0, 4'hf, 1'b0);
      addr_ok = 1'b1;
      settle(); chk("wr_reqA", d_addr, 32'h3000);
      step(); addr_ok = 1'b0; data_ok = 1'b1;
      ce = 1'b1; st_addr = 32'h3008; st_wdata = 32'hC0;
      settle(); chk("wr_wait_req", req, 0);
      step(); data_ok = 1'b0; ce = 1'b0;
      settle(); chk("wr_full0", full, 0);
      chk("wr_req", req, 1);
      chk("wr_headB", d_addr, 32'h3004);
      step();
      enq(32'h300C, 32'hD0, 4'hf, 1'b0);
      settle(); chk("wr_cnt3", full, 0);
      step();
      enq(32'h3010, 32'hE0, 4'hf, 1'b0);
      settle(); chk("wr_cnt4", full, 1);
      step();
      ea_q = '{32'h3004, 32'h3008, 32'h300C, 32'h3010};
      ed_q = '{32'hB0, 32'hC0, 32'hD0, 32'hE0};
      drain("wr");

      // fill to full, 5th enqueue ignored, drain in order
      for (int i = 0; i < 4; i++) begin
         enq(32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i),
             4'hf, 1'b0);
         settle();
         chk($sformatf("fill_full%0d", i), full, (i == 3));
         step();
      end
      enq(32'h200, 32'hBAD, 4'hf, 1'b0);
      settle(); chk("fill_full5", full, 1);
      ld_valid = 1'b1; ld_addr = 32'h200;
      #1 chk("fill_ign_hz", hazard, 0);
      ld_valid = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         ea_q.push_back(32'h100 + 32'(4*i));
         ed_q.push_back(32'hC0DE0000 + 32'(i));
      end
      drain("fill");

      // youngest cacheable full-word store forwards
      enq(32'h2000, 32'hAAAA0000, 4'hf, 1'b0);
      enq(32'h2000, 32'hBBBB1111, 4'hf, 1'b0);
      ld_valid = 1'b1; ld_addr = 32'h2000;
      settle();
`ifdef MM_STORE_BUFFER_FWD_EN
      chk("fwd_hit", fwd_hit, 1);
      chk("fwd_data", fwd_data, 32'hBBBB1111);
      chk("fwd_hz", hazard, 0);
`else
      chk("fwd_hit", fwd_hit, 0);
      chk("fwd_data", fwd_data, 0);
      chk("fwd_hz", hazard, 1);
`endif
      step();
      enq(32'h2000, 32'hCCCC2222, 4'hf, 1'b1);
      settle();
      chk("unc_hz", hazard, 1);
      chk("unc_hit", fwd_hit, 0);
      ld_valid = 1'b0;
      step();
      ea_q = '{32'h2000, 32'h2000, 32'h2000};
      ed_q = '{32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222};
      drain("fwd");

      // reset while waiting for data_ok with 3 entries
      enq(32'h4000, 32'h1, 4'hf, 1'b0);
      enq(32'h4004, 32'h2, 4'hf, 1'b0);
      enq(32'h4008, 32'h3, 4'hf, 1'b0);
      addr_ok = 1'b1;
      begin
         int n;
         n = 0;
         settle();
         while (!req && n < 10) begin
            step(); settle(); n++;
         end
         chk("rw_req_seen", req, 1);
      end
      step(); addr_ok = 1'b0;
      settle(); chk("rw_wait", req, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_rst_req", req, 0);
      chk("rw_rst_empty", empty, 1);
      chk("rw_rst_full", full, 0);
      ld_valid = 1'b1; ld_addr = 32'h4000;
      #1 chk("rw_rst_hz", hazard, 0);
      ld_valid = 1'b0;
      step(); rst_n = 1'b1;
      step(); data_ok = 1'b1;
      settle(); chk("rw_dok_empty", empty, 1);
      step(); data_ok = 1'b0;
      settle(); chk("rw_after_req", req, 0);
      chk("rw_after_empty", empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
